// File: rtl/ste_avg_seq.sv
// ste_avg_seq: drives an IIR averager over an N-sample burst and returns the final average as one result.
// Optional idle-sample timeout in RUN is enabled by defining STE_AVG_SEQ_TIMEOUT_EN.
module ste_avg_seq #(
    parameter int DATA_W      = 16,
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  num_smp_i,
    input  logic [DATA_W-1:0] smp_i,
    input  logic              smp_vld_i,
    output logic              smp_rdy_o,
    output logic [DATA_W-1:0] avg_din_o,
    output logic              avg_clr_o,
    output logic              avg_en_o,
    input  logic [DATA_W-1:0] avg_dout_i,
    input  logic              avg_update_i,
    output logic [DATA_W-1:0] res_o,
    output logic              res_vld_o,
    input  logic              res_rdy_i,
    output logic              busy_o,
    output logic              err_o
);
    typedef enum logic [2:0] {IDLE, CLR, RUN, LAST, CHK, HOLD} state_t;
    state_t state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d, cnt_q, cnt_d;
    logic [DATA_W-1:0] din_q, din_d, res_q, res_d;
    logic clr_q, clr_d, en_q, en_d, err_q, err_d;
    logic acc;
`ifdef STE_AVG_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] idle_q, idle_d;
`endif
    assign smp_rdy_o = (state_q == RUN) && (cnt_q < n_q);
    assign acc       = smp_vld_i && smp_rdy_o;
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        cnt_d   = acc ? cnt_q + 1'b1 : cnt_q;
        din_d   = acc ? smp_i : din_q;
        res_d   = res_q;
        clr_d   = 1'b0;
        en_d    = acc;
        err_d   = 1'b0;
`ifdef STE_AVG_SEQ_TIMEOUT_EN
        idle_d  = idle_q;
`endif
        case (state_q)
            IDLE: if (start_i) begin
                if (num_smp_i == '0) err_d = 1'b1;
                else begin
                    n_d     = num_smp_i;
                    clr_d   = 1'b1;
                    din_d   = '0;
                    state_d = CLR;
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
`ifdef STE_AVG_SEQ_TIMEOUT_EN
                idle_d  = '0;
`endif
            end
            RUN: begin
                if (acc && cnt_q == n_q - 1'b1) state_d = LAST;
`ifdef STE_AVG_SEQ_TIMEOUT_EN
                // Abandon the burst once the source has been silent for TIMEOUT_CYC cycles.
                if (acc) idle_d = '0;
                else if (idle_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    clr_d   = 1'b1;
                    state_d = IDLE;
                end else idle_d = idle_q + 1'b1;
`endif
            end
            LAST: begin
                res_d   = avg_dout_i;
                state_d = CHK;
            end
            CHK: if (avg_update_i) state_d = HOLD;
            else begin
                err_d   = 1'b1;
                res_d   = '0;
                state_d = IDLE;
            end
            HOLD: if (res_rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            res_q   <= '0;
            clr_q   <= 1'b0;
            en_q    <= 1'b0;
            err_q   <= 1'b0;
`ifdef STE_AVG_SEQ_TIMEOUT_EN
            idle_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            res_q   <= res_d;
            clr_q   <= clr_d;
            en_q    <= en_d;
            err_q   <= err_d;
`ifdef STE_AVG_SEQ_TIMEOUT_EN
            idle_q  <= idle_d;
`endif
        end
    end
    assign avg_din_o = din_q;
    assign avg_clr_o = clr_q;
    assign avg_en_o  = en_q;
    assign res_o     = res_q;
    assign res_vld_o = (state_q == HOLD);
    assign busy_o    = (state_q != IDLE);
    assign err_o     = err_q;
endmodule

// File: tb/tb_ste_avg_seq.sv
// tb_ste_avg_seq: table-driven, hand-written and random bursts against ste_avg_seq with an IIR averager stand-in.
module tb_ste_avg_seq;
    localparam int DW = 16;
    localparam int CW = 8;
    logic clk = 1'b0, rst;
    logic start_i, smp_vld_i, smp_rdy_o, avg_clr_o, avg_en_o, avg_update_i;
    logic res_vld_o, res_rdy_i, busy_o, err_o;
    logic [CW-1:0] num_smp_i;
    logic [DW-1:0] smp_i, avg_din_o, avg_dout_i, res_o;
    int checks = 0, errors = 0;

    ste_avg_seq #(.DATA_W(DW), .CNT_W(CW), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .num_smp_i(num_smp_i),
        .smp_i(smp_i), .smp_vld_i(smp_vld_i), .smp_rdy_o(smp_rdy_o),
        .avg_din_o(avg_din_o), .avg_clr_o(avg_clr_o), .avg_en_o(avg_en_o),
        .avg_dout_i(avg_dout_i), .avg_update_i(avg_update_i),
        .res_o(res_o), .res_vld_o(res_vld_o), .res_rdy_i(res_rdy_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Averager stand-in: y += round((x - y) / 8); output shows the updated value during the enable cycle.
    function automatic logic [DW-1:0] avg_step(input logic [DW-1:0] y, input logic [DW-1:0] x);
        int d;
        d = int'(x) - int'(y) + 4;
        return DW'(int'(y) + (d >>> 3));
    endfunction

    logic [DW-1:0] acc_q;
    logic upd_q, kill;
    assign avg_dout_i   = avg_en_o ? avg_step(acc_q, avg_din_o) : acc_q;
    assign avg_update_i = upd_q & ~kill;
    always @(posedge clk) begin
        if (rst || avg_clr_o) acc_q <= '0;
        else if (avg_en_o) acc_q <= avg_step(acc_q, avg_din_o);
        upd_q <= avg_en_o;
    end

    logic [DW-1:0] smp_q[$];

    function automatic logic [DW-1:0] ref_avg();
        logic [DW-1:0] y;
        y = '0;
        foreach (smp_q[i]) y = avg_step(y, smp_q[i]);
        return y;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic burst(input int n, input logic [6:0] pat, input bit rnd_vld, input int wait_c,
                         input bit poke, input bit kill_upd, input logic [DW-1:0] exp_res);
        int got, k;
        bit pend;
        logic [DW-1:0] pv;
        got = 0; k = 0; pend = 1'b0; pv = '0;
        @(negedge clk); start_i = 1'b1; num_smp_i = CW'(n);
        @(negedge clk); start_i = 1'b0;
        chk("clr_pulse", avg_clr_o, 1); chk("clr_din", avg_din_o, 0);
        chk("clr_busy", busy_o, 1); chk("clr_en", avg_en_o, 0);
        @(negedge clk);
        chk("clr_one_cycle", avg_clr_o, 0);
        while (1) begin
            chk("en", avg_en_o, pend);
            if (pend) chk("din", avg_din_o, pv);
            if (got == n) break;
            if (k > 400) begin chk("burst_budget", got, n); break; end
            smp_vld_i = rnd_vld ? ($urandom_range(0, 2) != 0) : pat[6 - (k % 7)];
            smp_i     = smp_vld_i ? smp_q[got] : DW'($urandom);
            start_i   = poke && (k == 1);
            num_smp_i = CW'($urandom_range(0, 9));
            pend = smp_vld_i && smp_rdy_o;
            if (pend) begin pv = smp_i; got++; end
            k++;
            @(negedge clk);
        end
        chk("rdy_after_last", smp_rdy_o, 0);
        smp_vld_i = 1'b0; start_i = 1'b0; kill = kill_upd;
        @(negedge clk);
        chk("chk_vld", res_vld_o, 0); chk("chk_en", avg_en_o, 0);
        @(negedge clk);
        kill = 1'b0;
        if (kill_upd) begin
            chk("noupd_err", err_o, 1); chk("noupd_vld", res_vld_o, 0); chk("noupd_busy", busy_o, 0);
            @(negedge clk);
            chk("noupd_err_pulse", err_o, 0); chk("noupd_vld2", res_vld_o, 0);
            return;
        end
        chk("latency_vld", res_vld_o, 1); chk("res", res_o, exp_res); chk("hold_err", err_o, 0);
        repeat (wait_c) begin
            @(negedge clk);
            chk("hold_vld", res_vld_o, 1); chk("hold_res", res_o, exp_res);
        end
        res_rdy_i = 1'b1;
        @(negedge clk); res_rdy_i = 1'b0;
        chk("post_vld", res_vld_o, 0); chk("post_busy", busy_o, 0);
    endtask

    typedef struct {
        int n; logic [DW-1:0] val; logic [6:0] pat; int wait_c; bit poke; logic [DW-1:0] exp;
    } vec_t;
    vec_t tbl[6];

    initial begin
        #2000000;
        $display("FAIL watchdog time_limit_exceeded at %0t", $time);
        $fatal(1);
    end

    initial begin
        tbl[0] = '{3, 16'd800,   7'b1111111, 0, 1'b0, 16'd265};
        tbl[1] = '{1, 16'd800,   7'b1111111, 5, 1'b0, 16'd100};
        tbl[2] = '{4, 16'd80,    7'b1001101, 2, 1'b1, 16'd34};
        tbl[3] = '{2, 16'd800,   7'b1010101, 0, 1'b0, 16'd188};
        tbl[4] = '{2, 16'd65535, 7'b1111111, 1, 1'b0, 16'd15360};
        tbl[5] = '{1, 16'd0,     7'b1111111, 0, 1'b0, 16'd0};
        rst = 1'b1; start_i = 1'b0; num_smp_i = '0; smp_i = '0; smp_vld_i = 1'b0;
        res_rdy_i = 1'b0; kill = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rdy", smp_rdy_o, 0); chk("rst_din", avg_din_o, 0); chk("rst_clr", avg_clr_o, 0);
        chk("rst_en", avg_en_o, 0); chk("rst_res", res_o, 0); chk("rst_vld", res_vld_o, 0);
        chk("rst_busy", busy_o, 0); chk("rst_err", err_o, 0);
        rst = 1'b0;
        foreach (tbl[i]) begin
            smp_q.delete();
            repeat (tbl[i].n) smp_q.push_back(tbl[i].val);
            burst(tbl[i].n, tbl[i].pat, 1'b0, tbl[i].wait_c, tbl[i].poke, 1'b0, tbl[i].exp);
        end
        // Zero-length burst is rejected with an error pulse.
        @(negedge clk); start_i = 1'b1; num_smp_i = '0;
        @(negedge clk); start_i = 1'b0;
        chk("n0_err", err_o, 1); chk("n0_busy", busy_o, 0); chk("n0_clr", avg_clr_o, 0);
        @(negedge clk);
        chk("n0_err_pulse", err_o, 0); chk("n0_busy2", busy_o, 0);
        // Reset in the middle of a 5-sample burst.
        @(negedge clk); start_i = 1'b1; num_smp_i = 8'd5;
        @(negedge clk); start_i = 1'b0;
        @(negedge clk); smp_vld_i = 1'b1; smp_i = 16'd123;
        @(negedge clk);
        @(negedge clk); smp_vld_i = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("mrst_rdy", smp_rdy_o, 0); chk("mrst_din", avg_din_o, 0); chk("mrst_en", avg_en_o, 0);
        chk("mrst_vld", res_vld_o, 0); chk("mrst_busy", busy_o, 0); chk("mrst_res", res_o, 0);
        rst = 1'b0;
        smp_q.delete(); smp_q.push_back(16'd800); smp_q.push_back(16'd800);
        burst(2, 7'b1111111, 1'b0, 0, 1'b0, 1'b0, 16'd188);
        // Missing averager update in CHK discards the result.
        burst(2, 7'b1111111, 1'b0, 0, 1'b0, 1'b1, 16'd0);
`ifdef STE_AVG_SEQ_TIMEOUT_EN
        @(negedge clk); start_i = 1'b1; num_smp_i = 8'd2;
        @(negedge clk); start_i = 1'b0;
        repeat (16) @(negedge clk);
        chk("to_busy_before", busy_o, 1); chk("to_err_before", err_o, 0);
        @(negedge clk);
        chk("to_err", err_o, 1); chk("to_clr", avg_clr_o, 1); chk("to_busy", busy_o, 0);
        chk("to_vld", res_vld_o, 0);
        @(negedge clk);
        chk("to_err_pulse", err_o, 0); chk("to_clr_pulse", avg_clr_o, 0);
`endif
        for (int r = 0; r < 25; r++) begin
            int n;
            n = $urandom_range(1, 6);
            smp_q.delete();
            repeat (n) smp_q.push_back(DW'($urandom));
            burst(n, 7'b0, 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0, ref_avg());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ste_avg_seq.md
Name: ste_avg_seq

Overview:
Sequencer on the driving side of the ste IIR averager interface. It accepts a burst of N input samples over a valid/ready handshake and drives the averager's clear, enable and data lines. It captures the averaged value produced with the Nth sample and presents it as a single result over a valid/ready handshake. It sits between the sample source and the averager, and converts a streaming average into a per-burst result.

Parameters:
DATA_W, 16, width of samples, averager data and result
CNT_W, 8, width of the burst-length field (N max = 2^CNT_W-1)
TIMEOUT_CYC, 1024, idle-sample timeout in cycles (used only with STE_AVG_SEQ_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start_i  in  1  start burst (sampled in IDLE only)
num_smp_i  in  CNT_W  burst length N, latched on accepted start
smp_i  in  DATA_W  input sample
smp_vld_i  in  1  sample valid
smp_rdy_o  out  1  sample ready
avg_din_o  out  DATA_W  to averager din_i (registered)
avg_clr_o  out  1  to averager avg_clr_i (registered)
avg_en_o  out  1  to averager avg_en_i (registered)
avg_dout_i  in  DATA_W  from averager dout_o
avg_update_i  in  1  from averager dout_update_o
res_o  out  DATA_W  burst result
res_vld_o  out  1  result valid
res_rdy_i  in  1  result ready
busy_o  out  1  high in any state except IDLE
err_o  out  1  one-cycle error pulse

Behaviour:
- One clock, clk. rst is synchronous and active-high.
- Reset, including mid-burst: state IDLE; all outputs 0; count 0; res_o 0. No partial result is emitted.
- FSM states: IDLE, CLR, RUN, LAST, CHK, HOLD.
- IDLE:
  - start_i=1 with num_smp_i!=0: latch N, go to CLR.
  - start_i=1 with num_smp_i=0: err_o=1 for one cycle, stay in IDLE.
- CLR: avg_clr_o=1 and avg_din_o=0 for exactly one cycle, count cleared, go to RUN.
- RUN:
  - smp_rdy_o=1 combinationally while count<N.
  - A sample is accepted when smp_vld_i&smp_rdy_o. On the next cycle avg_din_o=smp_i and avg_en_o=1; count increments.
  - avg_en_o is 0 on cycles with no accepted sample. avg_din_o holds its last value.
  - Accepting the Nth sample: smp_rdy_o drops the following cycle, go to LAST.
- LAST: the cycle in which avg_en_o=1 for the Nth sample. Capture res_o<=avg_dout_i, go to CHK.
- CHK: avg_update_i must be 1.
  - If 1: go to HOLD.
  - If 0: err_o pulse, discard the result, go to IDLE.
- HOLD:
  - res_vld_o=1; res_o stable until res_rdy_i=1.
  - On the handshake cycle: res_vld_o falls next cycle, go to IDLE.
  - res_rdy_i high on the first HOLD cycle is a valid zero-wait handshake.
- start_i outside IDLE: ignored, no error.
- Throughput: one sample per cycle in RUN.
- Latency: acceptance of the Nth sample to res_vld_o=1 is 3 cycles.
- Back-to-back: start_i asserted in the IDLE cycle after HOLD is accepted.
- Averager arithmetic stays inside the averager; this block does no arithmetic beyond the CNT_W counter. The counter never wraps because count<=N.

Optional Feature:
STE_AVG_SEQ_TIMEOUT_EN
- Defined:
  - In RUN, a CNT idle counter increments on each cycle without an accepted sample and clears on acceptance.
  - When the counter reaches TIMEOUT_CYC: err_o pulse, avg_clr_o=1 for one cycle, go to IDLE with no result.
- Undefined: RUN waits indefinitely for samples; no timeout logic is present.

Test Plan:
- Reset then start N=3 with samples 800,800,800 back-to-back (loopback to ste_avg_iir, DATA_W=16) -> res_o=265, res_vld_o 3 cycles after the third acceptance, avg_clr_o one pulse before the first avg_en_o.
- Start N=1 with sample 800, res_rdy_i held 0 for 5 cycles then 1 -> res_o=100 held stable for all HOLD cycles; IDLE the cycle after the handshake; busy_o=0.
- Start N=0 -> err_o one-cycle pulse, busy_o stays 0, no avg_clr_o.
- N=4 with smp_vld_i gaps (pattern 1,0,0,1,1,0,1) and start_i pulsed during RUN -> exactly 4 avg_en_o pulses, start ignored, smp_rdy_o=0 after the 4th acceptance.
- Assert rst during RUN after 2 of 5 samples -> next cycle all outputs 0, IDLE; a new start N=2 completes normally.
- Force avg_update_i=0 in CHK -> err_o pulse, no res_vld_o. With STE_AVG_SEQ_TIMEOUT_EN and TIMEOUT_CYC=16: no samples for 16 cycles in RUN -> err_o pulse, avg_clr_o pulse, IDLE.
